// File: rtl/pic_ctrl_seq.sv
// pic_ctrl_seq: 8259-style interrupt acknowledge sequencer (8086 2-pulse / 8080 3-pulse INTA)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   INTA_n           CPU acknowledge pin (asynchronous, active-low)
//   INT_request      pending-interrupt level from the priority resolver
//   interrupt_index  winning line from the resolver
//   mode_8086        1 = 2-pulse acknowledge, 0 = 3-pulse 8080 acknowledge
//   single, SP       single-PIC system / master (1) or slave (0)
//   ICW3             slave-present mask (master) ; cascade_match = this slave addressed
//   write_flag, read_busy  register access in progress, suppresses INT
//   EOI              end-of-interrupt pulse
//   INT              interrupt request to the CPU
//   freezing         acknowledge in progress (resolver must hold)
//   latch_ISR        one-cycle pulse to set the in-service bit
//   vector_oe, vector_sel  data bus drive enable and byte select (0 opcode, 1 low, 2 high)
//   cascade_en, desired_slave  drive cascade lines with the selected slave id
//   abort            one-cycle pulse when the CPU stops acknowledging
//   captured_index   line index frozen at the first acknowledge edge
module pic_ctrl_seq #(
    parameter int N_IRQ   = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             INTA_n,
    input  logic             INT_request,
    input  logic [IDX_W-1:0] interrupt_index,
    input  logic             mode_8086,
    input  logic             single,
    input  logic             SP,
    input  logic [N_IRQ-1:0] ICW3,
    input  logic             cascade_match,
    input  logic             write_flag,
    input  logic             read_busy,
    input  logic             EOI,
    output logic             INT,
    output logic             freezing,
    output logic             latch_ISR,
    output logic             vector_oe,
    output logic [1:0]       vector_sel,
    output logic             cascade_en,
    output logic [IDX_W-1:0] desired_slave,
    output logic             abort,
    output logic [IDX_W-1:0] captured_index
);
    typedef enum logic [2:0] {IDLE, PEND, ACK1, ACK2, ACK3} state_t;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    state_t      state, nxt;
    logic        s1, s2, d;
    logic        fall, rise, in_ack, tmo, ent, casc, gate;
    logic        m_q, cas_q, slv_q;
    logic [15:0] cnt;
    assign fall   = d & ~s2;
    assign rise   = ~d & s2;
    assign in_ack = (state == ACK1) | (state == ACK2) | (state == ACK3);
    // an INTA edge restarts the count, so it always wins over an expiring timer
    assign tmo    = in_ack & ~fall & ~rise & (cnt == TMO_LAST);
    assign ent    = (state == PEND) & (nxt == ACK1);
    assign casc   = SP & ~single & ICW3[interrupt_index];
    // gating uses the configuration frozen at ACK1 entry
    assign gate   = ~cas_q & (~slv_q | cascade_match);
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = (INT_request & ~write_flag & ~read_busy) ? PEND : IDLE;
            PEND: nxt = EOI ? IDLE : fall ? ACK1 : ~INT_request ? IDLE : PEND;
            ACK1: nxt = fall ? ACK2 : ACK1;
            ACK2: nxt = m_q ? (rise ? IDLE : ACK2) : (fall ? ACK3 : ACK2);
            ACK3: nxt = rise ? IDLE : ACK3;
            default: nxt = IDLE;
        endcase
        if (tmo) nxt = IDLE;
    end
    assign freezing   = in_ack;
    assign vector_sel = (state == ACK2) ? 2'd1 : (state == ACK3) ? 2'd2 : 2'd0;
    assign vector_oe  = ~s2 & (((state == ACK1) & ~m_q) | (((state == ACK2) | (state == ACK3)) & gate));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            s1             <= 1'b1;
            s2             <= 1'b1;
            d              <= 1'b1;
            cnt            <= '0;
            m_q            <= 1'b0;
            cas_q          <= 1'b0;
            slv_q          <= 1'b0;
            INT            <= 1'b0;
            latch_ISR      <= 1'b0;
            abort          <= 1'b0;
            cascade_en     <= 1'b0;
            desired_slave  <= '0;
            captured_index <= '0;
        end else begin
            state     <= nxt;
            s1        <= INTA_n;
            s2        <= s1;
            d         <= s2;
            cnt       <= ((nxt != state) | fall | rise) ? 16'd0 : (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            INT       <= (nxt == PEND) & ~write_flag & ~read_busy;
            latch_ISR <= ent;
            abort     <= tmo;
            if (ent) begin
                m_q            <= mode_8086;
                cas_q          <= casc;
                slv_q          <= ~single & ~SP;
                captured_index <= interrupt_index;
            end else if (tmo) begin
                captured_index <= '0;
            end
            cascade_en    <= ent ? casc : (EOI | (nxt == IDLE)) ? 1'b0 : cascade_en;
            desired_slave <= (ent & casc) ? interrupt_index : (nxt == IDLE) ? '0 : desired_slave;
        end
    end
endmodule

// File: tb/tb_pic_ctrl_seq.sv
// tb_pic_ctrl_seq: table-driven scoreboard bench for pic_ctrl_seq (TIMEOUT=10)
module tb_pic_ctrl_seq;
    localparam int TMO = 10;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       INTA_n = 1'b1, INT_request = 1'b0, mode_8086 = 1'b1, single = 1'b1, SP = 1'b1;
    logic       cascade_match = 1'b0, write_flag = 1'b0, read_busy = 1'b0, EOI = 1'b0;
    logic [2:0] interrupt_index = '0;
    logic [7:0] ICW3 = '0;
    logic       INT, freezing, latch_ISR, vector_oe, cascade_en, abort;
    logic [1:0] vector_sel;
    logic [2:0] desired_slave, captured_index;
    int         checks = 0, failures = 0;

    typedef struct {
        string       nm;
        logic        inta, req;
        logic [2:0]  idx;
        logic        wf, rb, eoi, m86, sgl, sp;
        logic [7:0]  icw3;
        logic        cm;
        int          n;
        logic [13:0] ex;
    } vec_t;
    vec_t        tbl[$];
    logic [13:0] exp_q[$];
    string       nm_q[$];

    pic_ctrl_seq #(.N_IRQ(8), .IDX_W(3), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .INTA_n(INTA_n), .INT_request(INT_request),
        .interrupt_index(interrupt_index), .mode_8086(mode_8086), .single(single), .SP(SP),
        .ICW3(ICW3), .cascade_match(cascade_match), .write_flag(write_flag), .read_busy(read_busy),
        .EOI(EOI), .INT(INT), .freezing(freezing), .latch_ISR(latch_ISR), .vector_oe(vector_oe),
        .vector_sel(vector_sel), .cascade_en(cascade_en), .desired_slave(desired_slave),
        .abort(abort), .captured_index(captured_index)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] E(logic i, logic f, logic l, logic o, logic [1:0] s,
                                      logic c, logic [2:0] ds, logic [2:0] cp, logic a);
        return {i, f, l, o, s, c, ds, cp, a};
    endfunction

    function automatic logic [13:0] act();
        return {INT, freezing, latch_ISR, vector_oe, vector_sel, cascade_en, desired_slave, captured_index, abort};
    endfunction

    task automatic add(input string nm, input logic inta, req, input logic [2:0] idx,
                       input logic wf, rb, eoi, m86, sgl, sp, input logic [7:0] icw3,
                       input logic cm, input int n, input logic [13:0] ex);
        vec_t v;
        v.nm = nm; v.inta = inta; v.req = req; v.idx = idx; v.wf = wf; v.rb = rb; v.eoi = eoi;
        v.m86 = m86; v.sgl = sgl; v.sp = sp; v.icw3 = icw3; v.cm = cm; v.n = n; v.ex = ex;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [13:0] ex);
        logic [13:0] a;
        a = act();
        checks++;
        if (a !== ex) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, ex);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int ex);
        checks++;
        if (a != ex) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, ex);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          k;
        logic [13:0] acc;
        add("idle",      1,0,0, 0,0,0, 1,1,1,8'h00,0, 1, E(0,0,0,0,0,0,0,0,0));
        add("idle_fall", 0,0,0, 0,0,0, 1,1,1,8'h00,0, 4, E(0,0,0,0,0,0,0,0,0));
        add("idle_rise", 1,0,0, 0,0,0, 1,1,1,8'h00,0, 4, E(0,0,0,0,0,0,0,0,0));
        add("a_pend",    1,1,5, 0,0,0, 1,1,1,8'h00,0, 1, E(1,0,0,0,0,0,0,0,0));
        add("a_ack1",    0,1,5, 0,0,0, 1,1,1,8'h00,0, 3, E(0,1,1,0,0,0,0,5,0));
        add("a_ack1_lo", 0,1,5, 0,0,0, 1,1,1,8'h00,0, 1, E(0,1,0,0,0,0,0,5,0));
        add("a_ack1_hi", 1,1,5, 0,0,0, 1,1,1,8'h00,0, 3, E(0,1,0,0,0,0,0,5,0));
        add("a_ack2",    0,1,5, 0,0,0, 1,1,1,8'h00,0, 3, E(0,1,0,1,1,0,0,5,0));
        add("a_ack2_hi", 1,1,5, 0,0,0, 1,1,1,8'h00,0, 2, E(0,1,0,0,1,0,0,5,0));
        add("a_idle",    1,1,5, 0,0,0, 1,1,1,8'h00,0, 1, E(0,0,0,0,0,0,0,5,0));
        add("a_repend",  1,1,5, 0,0,0, 1,1,1,8'h00,0, 1, E(1,0,0,0,0,0,0,5,0));
        add("a_drop",    1,0,5, 0,0,0, 1,1,1,8'h00,0, 1, E(0,0,0,0,0,0,0,5,0));
        add("b_pend",    1,1,3, 0,0,0, 0,1,1,8'h00,0, 1, E(1,0,0,0,0,0,0,5,0));
        add("b_ack1",    0,1,3, 0,0,0, 0,1,1,8'h00,0, 3, E(0,1,1,1,0,0,0,3,0));
        add("b_ack1_hi", 1,1,3, 0,0,0, 1,0,0,8'h00,0, 2, E(0,1,0,0,0,0,0,3,0));
        add("b_ack1_rs", 1,1,3, 0,0,0, 1,0,0,8'h00,0, 1, E(0,1,0,0,0,0,0,3,0));
        add("b_ack2",    0,1,3, 0,0,0, 1,0,0,8'h00,0, 3, E(0,1,0,1,1,0,0,3,0));
        add("b_ack2_hi", 1,1,3, 0,0,0, 1,0,0,8'h00,0, 3, E(0,1,0,0,1,0,0,3,0));
        add("b_ack3",    0,1,3, 0,0,0, 1,0,0,8'h00,0, 3, E(0,1,0,1,2,0,0,3,0));
        add("b_ack3_hi", 1,1,3, 0,0,0, 1,0,0,8'h00,0, 2, E(0,1,0,0,2,0,0,3,0));
        add("b_idle",    1,0,3, 0,0,0, 1,0,0,8'h00,0, 1, E(0,0,0,0,0,0,0,3,0));
        add("c_pend",    1,1,2, 0,0,0, 1,0,1,8'h04,0, 1, E(1,0,0,0,0,0,0,3,0));
        add("c_ack1",    0,1,2, 0,0,0, 1,0,1,8'h04,0, 3, E(0,1,1,0,0,1,2,2,0));
        add("c_ack1_hi", 1,1,2, 0,0,0, 1,0,1,8'h00,1, 3, E(0,1,0,0,0,1,2,2,0));
        add("c_ack2",    0,1,2, 0,0,0, 1,0,1,8'h00,1, 3, E(0,1,0,0,1,1,2,2,0));
        add("c_eoi",     0,1,2, 0,0,1, 1,0,1,8'h00,1, 1, E(0,1,0,0,1,0,2,2,0));
        add("c_idle",    1,0,2, 0,0,0, 1,0,1,8'h00,1, 3, E(0,0,0,0,0,0,0,2,0));
        add("d_pend",    1,1,1, 0,0,0, 1,0,0,8'h00,0, 1, E(1,0,0,0,0,0,0,2,0));
        add("d_ack1",    0,1,1, 0,0,0, 1,0,0,8'h00,0, 3, E(0,1,1,0,0,0,0,1,0));
        add("d_ack1_hi", 1,1,1, 0,0,0, 1,0,0,8'h00,0, 3, E(0,1,0,0,0,0,0,1,0));
        add("d_ack2_nm", 0,1,1, 0,0,0, 1,0,0,8'h00,0, 3, E(0,1,0,0,1,0,0,1,0));
        add("d_ack2_m",  0,1,1, 0,0,0, 1,0,0,8'h00,1, 1, E(0,1,0,1,1,0,0,1,0));
        add("d_idle",    1,0,1, 0,0,0, 1,0,0,8'h00,1, 3, E(0,0,0,0,0,0,0,1,0));
        add("e_wf_idle", 1,1,1, 1,0,0, 1,1,1,8'h00,0, 1, E(0,0,0,0,0,0,0,1,0));
        add("e_pend",    1,1,1, 0,0,0, 1,1,1,8'h00,0, 1, E(1,0,0,0,0,0,0,1,0));
        add("e_wf",      1,1,1, 1,0,0, 1,1,1,8'h00,0, 1, E(0,0,0,0,0,0,0,1,0));
        add("e_wf_hold", 1,1,1, 1,0,0, 1,1,1,8'h00,0, 2, E(0,0,0,0,0,0,0,1,0));
        add("e_wf_drop", 1,1,1, 0,0,0, 1,1,1,8'h00,0, 1, E(1,0,0,0,0,0,0,1,0));
        add("e_rb",      1,1,1, 0,1,0, 1,1,1,8'h00,0, 1, E(0,0,0,0,0,0,0,1,0));
        add("e_rb_drop", 1,1,1, 0,0,0, 1,1,1,8'h00,0, 1, E(1,0,0,0,0,0,0,1,0));
        add("e_eoi",     1,1,1, 0,0,1, 1,1,1,8'h00,0, 1, E(0,0,0,0,0,0,0,1,0));
        add("e_after",   1,0,1, 0,0,0, 1,1,1,8'h00,0, 1, E(0,0,0,0,0,0,0,1,0));

        cyc(2);
        check("rst_state", E(0,0,0,0,0,0,0,0,0));
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            INTA_n = tbl[i].inta; INT_request = tbl[i].req; interrupt_index = tbl[i].idx;
            write_flag = tbl[i].wf; read_busy = tbl[i].rb; EOI = tbl[i].eoi;
            mode_8086 = tbl[i].m86; single = tbl[i].sgl; SP = tbl[i].sp;
            ICW3 = tbl[i].icw3; cascade_match = tbl[i].cm;
            exp_q.push_back(tbl[i].ex);
            nm_q.push_back(tbl[i].nm);
            cyc(tbl[i].n);
            check(nm_q.pop_front(), exp_q.pop_front());
        end

        mode_8086 = 1'b1; single = 1'b1; SP = 1'b1; ICW3 = '0; cascade_match = 1'b0;
        INT_request = 1'b1; interrupt_index = 3'd6; INTA_n = 1'b0;
        cyc(4);
        check("to_ack1", E(0,1,0,0,0,0,0,6,0));
        INT_request = 1'b0; INTA_n = 1'b1;
        k = 0;
        while (k < 40 && !abort) begin
            cyc(1);
            k++;
        end
        check_int("to_latency", k, 3 + TMO);
        check("to_abort", E(0,0,0,0,0,0,0,0,1));
        cyc(1);
        check("to_pulse", E(0,0,0,0,0,0,0,0,0));

        INT_request = 1'b1; interrupt_index = 3'd4;
        cyc(1);
        INTA_n = 1'b0; cyc(3);
        INTA_n = 1'b1; cyc(3);
        INTA_n = 1'b0; cyc(3);
        check("r_ack2", E(0,1,0,1,1,0,0,4,0));
        #2 rst_n = 1'b0;
        #1 check("r_async", E(0,0,0,0,0,0,0,0,0));
        INTA_n = 1'b1; INT_request = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            acc = acc | act();
        end
        check("r_quiet", acc);
        if (acc !== 14'd0) $display("FAIL r_quiet_detail actual=%h required=0", acc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pic_ctrl_seq.md
PIC_CTRL_SEQ -- requirements
Module: pic_ctrl_seq

Interface
REQ-001 SHALL have parameter N_IRQ, default 8: number of interrupt lines; legal values 2, 4, 8, 16.
REQ-002 SHALL have parameter IDX_W, default 3: log2(N_IRQ).
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles between consecutive INTA pulses; legal range 1..65535.
REQ-004 SHALL have ports `clk  in  1`: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port `rst_n  in  1`: asynchronous, active-low reset.
REQ-006 SHALL have ports `INTA_n  in  1`: CPU acknowledge, asynchronous, active-low; and `INT_request  in  1`: level from priority resolver.
REQ-007 SHALL have port `interrupt_index  in  IDX_W`: winning line from the resolver.
REQ-008 SHALL have port `mode_8086  in  1`: 1 selects 2-pulse acknowledge; 0 selects 3-pulse (8080) acknowledge.
REQ-009 SHALL have ports `single  in  1`, `SP  in  1` (1 = master), `ICW3  in  N_IRQ` (slave-present mask) and `cascade_match  in  1` (slave addressed).
REQ-010 SHALL have ports `write_flag  in  1`, `read_busy  in  1` and `EOI  in  1` (one-cycle pulse).
REQ-011 SHALL have outputs `INT  out  1`, `freezing  out  1`, `latch_ISR  out  1` (pulse) and `vector_oe  out  1`.
REQ-012 SHALL have outputs `vector_sel  out  2` (0 = opcode/none, 1 = low byte, 2 = high byte), `cascade_en  out  1`, `desired_slave  out  IDX_W`, `abort  out  1` (pulse) and `captured_index  out  IDX_W`.

Function
REQ-013 SHALL synchronise INTA_n through two flops; a falling edge is a synchronised 1->0 transition, detected 3 cycles after the pin falls.
REQ-014 SHALL implement states IDLE, PEND, ACK1, ACK2 and ACK3.
REQ-015 SHALL move IDLE->PEND when INT_request=1, write_flag=0 and read_busy=0; INT SHALL be 1 in PEND and 0 in IDLE.
REQ-016 In PEND, INT_request=0 before any INTA edge SHALL return the block to IDLE next cycle, with no abort.
REQ-017 On the first INTA edge in PEND, the block SHALL move to ACK1, capture interrupt_index into captured_index, pulse latch_ISR for 1 cycle, set freezing=1 and drop INT.
REQ-018 In ACK1 with mode_8086=1: vector_sel SHALL be 0 and vector_oe 0; the next INTA edge SHALL move to ACK2.
REQ-019 In ACK1 with mode_8086=0: vector_oe=1 and vector_sel=0 (CALL opcode) while INTA_n sync is low; the next edge SHALL move to ACK2.
REQ-020 In ACK2: vector_oe=1 while INTA_n sync is low, and vector_sel=1. With mode_8086=1 the rising INTA edge SHALL go to IDLE; with mode_8086=0 the next falling edge SHALL go to ACK3.
REQ-021 In ACK3 (8080 only): vector_sel=2 and vector_oe=1 while INTA_n is low; the rising edge SHALL go to IDLE.
REQ-022 Cascade gating SHALL apply to vector_oe in ACK2/ACK3:
- single=1: unconditional.
- SP=1 and ICW3[captured_index]=1: vector_oe forced 0; cascade_en=1 and desired_slave=captured_index from ACK1 entry to return to IDLE.
- SP=0: vector_oe requires cascade_match=1.
REQ-023 freezing SHALL be 1 in ACK1, ACK2 and ACK3 only.
REQ-024 A 16-bit counter SHALL clear on each state entry and on each INTA edge. In ACK1/ACK2/ACK3, reaching TIMEOUT SHALL pulse abort for 1 cycle and return to IDLE with all outputs at reset values.
REQ-025 EOI=1 SHALL clear cascade_en in any state. In PEND it SHALL force IDLE; in ACKx it SHALL not change state.
REQ-026 The mode_8086, single, SP and ICW3 inputs SHALL be sampled at ACK1 entry; changes during ACKx SHALL be ignored.
REQ-027 write_flag or read_busy=1 in PEND SHALL hold INT=0 without leaving PEND; INT SHALL reassert when both are 0.
REQ-028 An INTA edge in IDLE SHALL be ignored, with no output change.
REQ-029 Re-entry to PEND SHALL require at least 1 cycle in IDLE after an acknowledge completes.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, clear the synchroniser to 1, zero the counter and drive every output to 0, including captured_index and desired_slave.
REQ-031 Reset asserted mid-acknowledge SHALL abandon the sequence with no abort pulse.

Verification
REQ-032 8086 master, single=1, idx=5: INT_request rises -> INT=1. Two INTA pulses -> latch_ISR once, captured_index=5, vector_sel=1 with vector_oe only during the 2nd low, then IDLE.
REQ-033 8080 mode: three INTA pulses -> vector_sel 0, 1, 2 across the pulses, vector_oe during each low, freezing=1 throughout.
REQ-034 Master, single=0, ICW3=8'h04, idx=2 -> cascade_en=1 and desired_slave=2, vector_oe never 1. EOI pulse -> cascade_en=0.
REQ-035 TIMEOUT=10, single INTA then none -> abort pulses at 10 cycles after the edge, state IDLE, freezing=0.
REQ-036 write_flag=1 with INT_request=1 -> INT=0; write_flag drops -> INT=1 next cycle. rst_n low during ACK2 -> all outputs 0 at once.
